input_debouncer: RTL
====================

// Module: input_debouncer
// PURPOSE
//   Conditions one raw asynchronous input, such as a push-button or switch, into a clean level.
//   Output dout drives the d input of the downstream df_f register stage.
//   Structure: 2-flop synchroniser, then a stability counter/FSM.
//   dout changes only after the synchronised input has held a new level for STABLE_CYCLES+1 consecutive cycles.
// PARAMETERS
//   STABLE_CYCLES  4  cycles the new level must persist beyond entry into a check state; must be >=1
//   RST_VAL        0  reset level of dout, of the synchroniser flops and of the FSM home state
//   CNT_W          $clog2(STABLE_CYCLES+1)  counter width; derived, do not override
// PORTS
//   clk         in   1  rising-edge clock
//   rst         in   1  asynchronous, active-high reset
//   din_raw     in   1  raw asynchronous input
//   dout        out  1  debounced level, registered
//   busy        out  1  high while a candidate transition is being checked
//   rise_pulse  out  1  one-cycle pulse when dout goes 0->1 (DEBOUNCE_EDGE_EN only)
//   fall_pulse  out  1  one-cycle pulse when dout goes 1->0 (DEBOUNCE_EDGE_EN only)
// BEHAVIOUR
//   Reset (async, rst=1):
//     sync flops = RST_VAL; dout = RST_VAL; cnt = 0; busy = 0; pulses = 0
//     state = S_HIGH if RST_VAL else S_LOW
//     Release is synchronous to the next clk edge.
//     Reset asserted mid-check aborts the check immediately with no dout change.
//   Synchroniser: s = din_raw delayed by 2 clk edges.
//   FSM states: S_LOW, S_RISE_CHK, S_HIGH, S_FALL_CHK. busy = 1 in both *_CHK states.
//   S_LOW:
//     s==1 -> S_RISE_CHK, cnt <= 1
//     else stay
//   S_RISE_CHK, evaluated in priority order:
//     1. s==0 -> S_LOW, cnt <= 0 (glitch rejected, dout unchanged)
//     2. cnt==STABLE_CYCLES -> S_HIGH, dout <= 1, cnt <= 0
//     3. otherwise cnt <= cnt+1
//   S_HIGH / S_FALL_CHK: mirror image of S_LOW / S_RISE_CHK with the levels inverted.
//   Latency:
//     Let E be the first edge sampling the new raw level, held thereafter.
//     dout changes at edge E+STABLE_CYCLES+2.
//   Boundary conditions:
//     Raw pulse of <= STABLE_CYCLES cycles: fully rejected, and the FSM returns to its home state.
//     Raw pulse of >= STABLE_CYCLES+1 cycles: accepted.
//     cnt never exceeds STABLE_CYCLES; there is no wrap-around.
//     Input bouncing during a check restarts the count from the next entry into the check state.
//   dout is driven straight from a flop, with no combinational path from din_raw.
// CONFIGURATION
//   Macro DEBOUNCE_EDGE_EN.
//   Defined:
//     rise_pulse/fall_pulse ports exist.
//     Each is a registered pulse asserted for exactly one cycle, on the same edge that dout changes.
//     Both pulses are never high together.
//   Undefined:
//     Ports and pulse logic are absent.
//     dout/busy timing is identical either way.
// STRUCTURE
//   Package debounce_pkg:
//     typedef enum logic [1:0] {S_LOW, S_RISE_CHK, S_HIGH, S_FALL_CHK} deb_state_t
//     localparam SYNC_STAGES = 2
//   Sub-module sync_2ff:
//     ports: clk, rst, RST_VAL param, d, q
//     async active-high reset
//     instantiated once for din_raw
//   Top level: FSM, counter, output regs, optional pulse regs.
// TESTING (STABLE_CYCLES=4, RST_VAL=0 unless noted)
//   1. Reset value: rst=1 with din_raw=1 -> dout=0, busy=0, pulses=0.
//      After release, din_raw held at 1 -> dout=1 at edge E+6.
//   2. Glitch reject: raw high for 4 cycles, then low -> dout stays 0.
//      busy high for 4 cycles, then back to 0 in S_LOW.
//   3. Minimum accept: raw high for 5 cycles -> dout=1 at E+6.
//      dout then falls 6 edges after raw drops, provided raw stays low.
//   4. Bounce: raw toggles 1,0,1,1,0,1 then holds 1 -> dout rises exactly 6 edges after the final 0->1 edge.
//   5. Mid-check reset: assert rst while busy=1 -> dout, busy and cnt clear asynchronously, the same cycle.
//      RST_VAL=1 run: dout=1 and state S_HIGH after reset.
//   6. DEBOUNCE_EDGE_EN: full rise then fall -> rise_pulse is a single 1-cycle pulse on the edge dout goes 0->1.
//      fall_pulse behaves likewise on the 1->0 edge. Both pulses are never high in the same cycle.

Source files
------------

// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared FSM state type and synchroniser depth for input_debouncer
package debounce_pkg;

  typedef enum logic [1:0] {
    S_LOW,
    S_RISE_CHK,
    S_HIGH,
    S_FALL_CHK
  } deb_state_t;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for one asynchronous bit
module sync_2ff
  import debounce_pkg::*;
#(
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sr;

  // shift the raw bit through the chain; only the last stage is used downstream
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= {SYNC_STAGES{RST_VAL}};
    end else begin
      sr <= {sr[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sr[SYNC_STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - synchronise and debounce one raw input; DEBOUNCE_EDGE_EN adds edge pulses
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter bit RST_VAL       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din_raw,
  output logic dout,
`ifdef DEBOUNCE_EDGE_EN
  output logic busy,
  output logic rise_pulse,
  output logic fall_pulse
`else
  output logic busy
`endif
);

  // counter only has to reach STABLE_CYCLES, so it never wraps
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam deb_state_t HOME = RST_VAL ? S_HIGH : S_LOW;

  logic             s;
  deb_state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             dout_n;
`ifdef DEBOUNCE_EDGE_EN
  logic             rise_n, fall_n;
`endif

  sync_2ff #(.RST_VAL(RST_VAL)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (din_raw),
    .q   (s)
  );

  // state, counter and output registers; reset aborts any check in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= HOME;
      cnt   <= '0;
      dout  <= RST_VAL;
`ifdef DEBOUNCE_EDGE_EN
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      dout  <= dout_n;
`ifdef DEBOUNCE_EDGE_EN
      rise_pulse <= rise_n;
      fall_pulse <= fall_n;
`endif
    end
  end

  // next-state: enter a check on a level change, abort on bounce, commit once the count is reached
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dout_n  = dout;
`ifdef DEBOUNCE_EDGE_EN
    rise_n  = 1'b0;
    fall_n  = 1'b0;
`endif
    case (state)
      S_LOW: begin
        if (s) begin
          state_n = S_RISE_CHK;
          cnt_n   = CNT_W'(1);
        end
      end
      S_RISE_CHK: begin
        if (!s) begin
          state_n = S_LOW;
          cnt_n   = '0;
        end else if (cnt == CNT_MAX) begin
          state_n = S_HIGH;
          dout_n  = 1'b1;
          cnt_n   = '0;
`ifdef DEBOUNCE_EDGE_EN
          rise_n  = 1'b1;
`endif
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_HIGH: begin
        if (!s) begin
          state_n = S_FALL_CHK;
          cnt_n   = CNT_W'(1);
        end
      end
      S_FALL_CHK: begin
        if (s) begin
          state_n = S_HIGH;
          cnt_n   = '0;
        end else if (cnt == CNT_MAX) begin
          state_n = S_LOW;
          dout_n  = 1'b0;
          cnt_n   = '0;
`ifdef DEBOUNCE_EDGE_EN
          fall_n  = 1'b1;
`endif
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = HOME;
        cnt_n   = '0;
      end
    endcase
  end

  assign busy = (state == S_RISE_CHK) || (state == S_FALL_CHK);

endmodule
